booth_csa_mul_iter: RTL
=======================

Name: booth_csa_mul_iter

Overview:
- Parametrised, multi-cycle radix-4 Booth multiplier with a valid/ready handshake.
- Each cycle it generates PP_PER_CYC Booth partial products and folds them into a redundant sum/carry accumulator using 3:2 CSA rows.
- A final carry-propagate add produces the 2*WIDTH product.
- Sits in the execute-stage multiply path and supports signed/unsigned operand modes and abort.

Parameters:
- WIDTH, 32, operand width; even, >= 4
- PP_PER_CYC, 4, Booth partial products compressed per cycle; 1..NPP

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- a  in  WIDTH  multiplicand
- b  in  WIDTH  multiplier (Booth-recoded)
- a_signed  in  1  1 = a is two's complement, 0 = unsigned
- b_signed  in  1  1 = b is two's complement, 0 = unsigned
- flush  in  1  synchronous abort
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- product  out  2*WIDTH  a*b, modulo 2^(2*WIDTH)

Behaviour:
- Derived constants:
  - NPP = WIDTH/2+1
  - ITER = ceil(NPP/PP_PER_CYC)
- Operand extension: a and b are each extended to WIDTH+2 bits, sign-extended if *_signed, else zero-extended.
  - b_ext is recoded into NPP radix-4 digits in {-2..+2}, digit i taken from b_ext[2i+1:2i-1] with b_ext[-1]=0.
- Partial product i = digit_i*a_ext, sign-extended to 2*WIDTH and shifted left by 2i. Negation is done as ones-complement plus a +1 injected at bit 2i of the same row.
- Accumulator: sum_q and carry_q, 2*WIDTH each. All arithmetic is modulo 2^(2*WIDTH); bits above 2*WIDTH-1 are discarded, including the carry shift.
- FSM states IDLE, COMP, ADD, DONE:
  - IDLE: in_ready=1. On in_valid, latch operands and modes, clear sum_q/carry_q, set iter_q=0, go to COMP.
  - COMP: each cycle adds partial products iter_q*PP_PER_CYC .. +PP_PER_CYC-1 into the accumulator through a CSA chain, then iter_q++.
    - Digit indices >= NPP contribute zero (last-iteration masking).
    - After iteration ITER-1, go to ADD.
  - ADD: product_q <= sum_q + carry_q (one CPA), then go to DONE.
  - DONE: out_valid=1 and product is held stable. On out_ready, go to IDLE.
- Latency: accept edge to out_valid is ITER+1 cycles. Defaults: ITER=5, so 6 cycles.
  - Throughput is one op per ITER+3 cycles; no overlap.
- in_ready=1 only in IDLE. in_valid in any other state is ignored and not queued.
- out_valid=1 only in DONE. out_ready outside DONE has no effect.
- flush: in any state, forces IDLE on the next edge with out_valid=0. It takes priority over in_valid, out_ready and the normal transitions. Accumulators need not be cleared.
- Reset (asynchronous, any time including mid-COMP): state=IDLE, in_ready=1, out_valid=0, product=0, sum_q=carry_q=0, iter_q=0.
- Operand latches are independent of later input changes.
- Elaboration-time error if WIDTH is odd or < 4, or if PP_PER_CYC is outside 1..NPP.

Decomposition:
- Shared package mul_pkg:
  - state encoding (IDLE, COMP, ADD, DONE)
  - functions npp(WIDTH) and iter(WIDTH, PP_PER_CYC)
  - Booth digit encoding constants (neg, one, two)
- Sub-module booth_pp_row: given a_ext, a 3-bit Booth window and a shift index, emits the 2*WIDTH partial-product row and its +1 correction bit.
- The existing parametrised csa module is reused; PP_PER_CYC instances are chained per cycle.

Test Plan:
- Signed a=32'hFFFFFFFF, b=32'hFFFFFFFF, both signed → product=64'h0000000000000001; out_valid exactly 6 cycles after the accept edge.
- Unsigned a=b=32'hFFFFFFFF → 64'hFFFFFFFE00000001. Signed a=b=32'h80000000 → 64'h4000000000000000.
- Mixed: a=32'hFFFFFFFE signed, b=32'h00000003 unsigned → 64'hFFFFFFFFFFFFFFFA. Unsigned a=32'hFFFFFFFE, b=3 → 64'h00000002FFFFFFFA.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and operands → product constant, in_ready=0, no new op accepted; after out_ready=1, in_ready=1 the next cycle.
- Reset asserted during COMP iteration 2 → out_valid=0 and in_ready=1 immediately. After release, 7*9 unsigned → 64'd63. flush during ADD → IDLE next cycle, out_valid never asserts.
- Parameter sweep (WIDTH=8, PP_PER_CYC=1 → NPP=5, latency 6; WIDTH=16, PP_PER_CYC=9): 10k random operands and modes checked against a behavioural 2*WIDTH reference product.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and helpers for the iterative radix-4 Booth multiplier.
// FSM state encoding, derived-size functions and Booth digit decode.
package mul_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMP,
    S_ADD,
    S_DONE
  } state_e;

  // Bit positions inside a decoded Booth digit {neg, two, one}
  localparam int BD_ONE = 0;
  localparam int BD_TWO = 1;
  localparam int BD_NEG = 2;

  function automatic int npp(input int w);
    return w / 2 + 1;
  endfunction

  function automatic int iter(input int w, input int p);
    return (npp(w) + p - 1) / p;
  endfunction

  // Window 3'b111 is treated as +0 rather than -0, so the top digit
  // (always 000/001/111 after extension) never needs a +1 correction.
  function automatic logic [2:0] booth_dec(input logic [2:0] w);
    logic [2:0] d;
    d = '0;
    d[BD_NEG] = w[2] & ~(w[1] & w[0]);
    d[BD_ONE] = w[1] ^ w[0];
    d[BD_TWO] = (w == 3'b011) | (w == 3'b100);
    return d;
  endfunction

endpackage

// File: rtl/booth_pp_row.sv
// One radix-4 Booth partial-product row, sign-extended and shifted.
// Ports: a_ext, Booth window, digit index, enable in; row and +1 bit out.
module booth_pp_row
  import mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IW    = 8
) (
  input  logic [WIDTH+1:0]   a_ext,
  input  logic [2:0]         win,
  input  logic [IW-1:0]      idx,
  input  logic               en,
  output logic [2*WIDTH-1:0] row,
  output logic               cor
);

  localparam int XW = WIDTH + 3;
  localparam int PW = 2 * WIDTH;

  logic [2:0]    dec;
  logic [XW-1:0] mag;
  logic [XW-1:0] flip;
  logic [PW-1:0] ext;

  always_comb begin
    dec  = booth_dec(win) & {3{en}};
    mag  = '0;
    if (dec[BD_TWO]) begin
      mag = {a_ext, 1'b0};
    end else if (dec[BD_ONE]) begin
      mag = {a_ext[WIDTH+1], a_ext};
    end
    // Negative digits: ones-complement here, +1 injected by the caller
    flip = mag ^ {XW{dec[BD_NEG]}};
    ext  = {{(PW-XW){flip[XW-1]}}, flip};
    row  = ext << {idx, 1'b0};
    cor  = dec[BD_NEG];
  end

endmodule

// File: rtl/csa.sv
// Parametrised 3:2 carry-save adder row.
// Ports: x/y/z addends in; s sum, c carry (already shifted left by one).
module csa #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] s,
  output logic [W-1:0] c
);

  logic [W-1:0] maj;

  assign s   = x ^ y ^ z;
  assign maj = (x & y) | (x & z) | (y & z);
  // Carry out of the top bit is dropped: arithmetic is modulo 2^W
  assign c   = {maj[W-2:0], 1'b0};

endmodule

// File: rtl/booth_csa_mul_iter.sv
// Multi-cycle radix-4 Booth multiplier, CSA accumulate then one CPA.
// Ports: clk/reset_n, in_valid/in_ready + a/b/modes, flush, out_valid/out_ready + product.
module booth_csa_mul_iter
  import mul_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int PP_PER_CYC = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               a_signed,
  input  logic               b_signed,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int NPP  = npp(WIDTH);
  localparam int ITER = iter(WIDTH, PP_PER_CYC);
  localparam int PW   = 2 * WIDTH;
  localparam int EW   = WIDTH + 2;
  localparam int TW   = $clog2(ITER + 1);
  localparam int IW   = $clog2(ITER * PP_PER_CYC + 1) + 1;
  localparam int PP   = PP_PER_CYC;

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("booth_csa_mul_iter: WIDTH must be even and >= 4");
  end
  if (PP_PER_CYC < 1 || PP_PER_CYC > NPP) begin : g_bad_pp
    $error("booth_csa_mul_iter: PP_PER_CYC must be in 1..NPP");
  end

  state_e        state_q, state_d;
  logic [EW-1:0] a_ext_q, a_ext_d;
  logic [EW-1:0] b_ext_q, b_ext_d;
  logic [PW-1:0] sum_q, sum_d;
  logic [PW-1:0] carry_q, carry_d;
  logic [TW-1:0] iter_q, iter_d;
  logic [PW-1:0] product_q, product_d;

  // b_ext with the implicit b_ext[-1]=0 appended at the bottom
  logic [EW:0]   bpad;
  logic [IW-1:0] pidx;
  logic [EW:0]   psh;
  logic [2:0]    pdec;
  logic          pcor;

  logic [IW-1:0] idx  [PP];
  logic [EW:0]   wsh  [PP];
  logic [2:0]    win  [PP];
  logic          en   [PP];
  logic [PW-1:0] row  [PP];
  logic          cor  [PP];
  logic          pc   [PP];
  logic [PW-1:0] inj  [PP];
  logic [PW-1:0] cs_s [PP+1];
  logic [PW-1:0] cs_c [PP+1];

  assign bpad = {b_ext_q, 1'b0};

  // Correction owed by the last digit of the previous cycle
  assign pidx = idx[0] - IW'(1);
  assign psh  = bpad >> {pidx, 1'b0};
  assign pdec = booth_dec(psh[2:0]);
  assign pcor = (iter_q != '0) & pdec[BD_NEG];

  assign cs_s[0] = sum_q;
  assign cs_c[0] = carry_q;

  for (genvar j = 0; j < PP; j++) begin : g_row
    assign idx[j] = IW'(iter_q) * IW'(PP) + IW'(j);
    assign wsh[j] = bpad >> {idx[j], 1'b0};
    assign win[j] = wsh[j][2:0];
    assign en[j]  = idx[j] < IW'(NPP);

    booth_pp_row #(
      .WIDTH (WIDTH),
      .IW    (IW)
    ) u_row (
      .a_ext (a_ext_q),
      .win   (win[j]),
      .idx   (idx[j]),
      .en    (en[j]),
      .row   (row[j]),
      .cor   (cor[j])
    );

    if (j == 0) begin : g_first
      assign pc[j] = pcor;
    end else begin : g_next
      assign pc[j] = cor[j-1];
    end

    // Row k is zero below bit 2k, so row k-1's +1 rides at bit 2k-2
    assign inj[j] = row[j] | ((PW'(pc[j]) << {idx[j], 1'b0}) >> 2);

    csa #(
      .W (PW)
    ) u_csa (
      .x (cs_s[j]),
      .y (cs_c[j]),
      .z (inj[j]),
      .s (cs_s[j+1]),
      .c (cs_c[j+1])
    );
  end

  always_comb begin
    state_d   = state_q;
    a_ext_d   = a_ext_q;
    b_ext_d   = b_ext_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    iter_d    = iter_q;
    product_d = product_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_ext_d = {{2{a_signed & a[WIDTH-1]}}, a};
          b_ext_d = {{2{b_signed & b[WIDTH-1]}}, b};
          sum_d   = '0;
          carry_d = '0;
          iter_d  = '0;
          state_d = S_COMP;
        end
      end
      S_COMP: begin
        sum_d   = cs_s[PP];
        carry_d = cs_c[PP];
        iter_d  = iter_q + TW'(1);
        if (iter_q == TW'(ITER - 1)) begin
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        product_d = sum_q + carry_q;
        state_d   = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      a_ext_q   <= '0;
      b_ext_q   <= '0;
      sum_q     <= '0;
      carry_q   <= '0;
      iter_q    <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_ext_q   <= a_ext_d;
      b_ext_q   <= b_ext_d;
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      iter_q    <= iter_d;
      product_q <= product_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign product   = product_q;

endmodule
